// File: rtl/spi8_master_pkg.sv
// Shared spi8 definitions: frame geometry, master FSM states and slave register map.
package spi8_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int RW_BIT  = 15;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    TAIL,
    DONE
  } state_e;

  localparam logic [ADDR_W-1:0] REG_ADDR0 = 7'h00;
  localparam logic [ADDR_W-1:0] REG_ADDR1 = 7'h01;
  localparam logic [ADDR_W-1:0] REG_ADDR2 = 7'h02;
  localparam logic [ADDR_W-1:0] REG_ADDR3 = 7'h03;
  localparam logic [ADDR_W-1:0] REG_ADDR4 = 7'h04;
  localparam logic [ADDR_W-1:0] REG_ADDR5 = 7'h05;
  localparam logic [ADDR_W-1:0] REG_ADDR6 = 7'h06;
  localparam logic [ADDR_W-1:0] REG_ADDR7 = 7'h07;

  // Reads carry an all-zero data field so the slave sees a clean frame.
  function automatic logic [FRAME_W-1:0] build_frame(input logic             rw,
                                                     input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] wdata);
    return {rw, addr, (rw ? {DATA_W{1'b0}} : wdata)};
  endfunction

endpackage

// File: rtl/spi8_master_if.sv
// Command handshake plus SPI pad signals of spi8_master; the master modport is the
// block's view, the slave modport is the view of whoever drives commands and the pads.
interface spi8_master_if;
  import spi8_pkg::*;

  logic              start;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              SCLK;
  logic              MOSI;
  logic              SV_n;
  logic              MISO;

  modport master (
    input  start, rw, addr, wdata, MISO,
    output busy, done, rdata, SCLK, MOSI, SV_n
  );

  modport slave (
    output start, rw, addr, wdata, MISO,
    input  busy, done, rdata, SCLK, MOSI, SV_n
  );

endinterface

// File: rtl/spi8_master_clkgen.sv
// Half-period timer: one-cycle tick every CLK_DIV cycles while enabled; cleared when
// disabled so the first tick after enable lands exactly CLK_DIV cycles later.
module spi8_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi8_master.sv
// spi8 initiator: one 16-bit frame per command, then TAIL_CLKS SCLK periods with SV_n high.
// busy lasts (34+2*TAIL_CLKS)*CLK_DIV cycles; start is ignored while busy, nothing queues.
module spi8_master
  import spi8_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int TAIL_CLKS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  spi8_master_if.master bus
);

  localparam int            TW        = (TAIL_CLKS > 1) ? $clog2(TAIL_CLKS) : 1;
  localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_CLKS - 1);

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [4:0]          bit_q, bit_d;
  logic [TW-1:0]       tail_q, tail_d;
  logic                phase_q, phase_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                sv_n_q, sv_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tick;

  spi8_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (busy_q),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      tail_q  <= '0;
      phase_q <= 1'b0;
      rw_q    <= 1'b0;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      sv_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      tail_q  <= tail_d;
      phase_q <= phase_d;
      rw_q    <= rw_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      sv_n_q  <= sv_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // phase_q tracks the SCLK level the FSM is currently timing (1 = high phase).
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    tail_d  = tail_q;
    phase_d = phase_q;
    rw_d    = rw_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = SETUP;
          tx_d    = build_frame(bus.rw, bus.addr, bus.wdata);
          rw_d    = bus.rw;
          bit_d   = '0;
          phase_d = 1'b0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
          phase_d = 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (phase_q) begin
            // End of high phase: sample the data half, then present the next bit.
            phase_d = 1'b0;
            tx_d    = {tx_q[FRAME_W-2:0], 1'b0};
            if (bit_q[3]) begin
              rx_d = {rx_q[DATA_W-2:0], bus.MISO};
            end
          end else if (bit_q == 5'd15) begin
            state_d = HOLD;
          end else begin
            bit_d   = bit_q + 5'd1;
            phase_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = TAIL;
          phase_d = 1'b1;
          tail_d  = '0;
        end
      end
      TAIL: begin
        if (tick) begin
          if (phase_q) begin
            phase_d = 1'b0;
          end else if (tail_q == TAIL_LAST) begin
            state_d = DONE;
          end else begin
            tail_d  = tail_q + 1'b1;
            phase_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DONE && rw_q) begin
      rdata_d = rx_q;
    end
  end

  // Pad outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    busy_d = (state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD) || (state_d == TAIL);
    sv_n_d = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
    sclk_d = phase_d && ((state_d == SHIFT) || (state_d == TAIL));
    mosi_d = !sv_n_d && tx_d[RW_BIT];
    done_d = (state_d == DONE);
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.SCLK  = sclk_q;
  assign bus.MOSI  = mosi_q;
  assign bus.SV_n  = sv_n_q;

endmodule

// File: tb/tb_spi8_master.sv
// Directed bench for spi8_master: default DUT plus a CLK_DIV=1/TAIL_CLKS=1 instance,
// each attached to a small spi8 slave register model.
module tb_spi8_master;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  spi8_master_if b0 ();
  spi8_master_if b1 ();

  spi8_master u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.master));
  spi8_master #(.CLK_DIV(1), .TAIL_CLKS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model state, one set per DUT.
  logic [7:0]  regs       [2][8];
  logic [15:0] sh         [2];
  logic [15:0] last_frame [2];
  logic [7:0]  obuf       [2];
  logic        so         [2];
  logic        sclk_p     [2];
  logic        sv_p       [2];
  int          cnt        [2];
  int          done_cnt   [2];
  int          win_cnt    [2];
  logic        sclk_w     [2];
  logic        sv_w       [2];
  logic        mosi_w     [2];
  logic        done_w     [2];

  assign sclk_w[0] = b0.SCLK;
  assign sclk_w[1] = b1.SCLK;
  assign sv_w[0]   = b0.SV_n;
  assign sv_w[1]   = b1.SV_n;
  assign mosi_w[0] = b0.MOSI;
  assign mosi_w[1] = b1.MOSI;
  assign done_w[0] = b0.done;
  assign done_w[1] = b1.done;
  assign b0.MISO   = so[0];
  assign b1.MISO   = so[1];

  // Slave: shifts SI on SCLK rise while selected, drives SO on SCLK fall, and commits
  // a complete write frame on the first SCLK rise seen with SV_n high.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!sv_w[k] && sv_p[k]) begin
        cnt[k] = 0;
        win_cnt[k]++;
      end
      if (sclk_w[k] && !sclk_p[k]) begin
        if (!sv_w[k]) begin
          sh[k] = {sh[k][14:0], mosi_w[k]};
          cnt[k]++;
          if (cnt[k] == 16) last_frame[k] = sh[k];
        end else if (cnt[k] == 16 && !sh[k][15]) begin
          regs[k][sh[k][10:8]] = sh[k][7:0];
          cnt[k] = 0;
        end
      end
      if (!sclk_w[k] && sclk_p[k] && !sv_w[k]) begin
        if (cnt[k] == 8) obuf[k] = regs[k][sh[k][2:0]];
        else             obuf[k] = obuf[k] << 1;
        so[k] = (cnt[k] >= 8) ? obuf[k][7] : 1'b0;
      end
      if (done_w[k]) done_cnt[k]++;
      sclk_p[k] = sclk_w[k];
      sv_p[k]   = sv_w[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue0(input logic rw, input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    b0.start = 1'b1;
    b0.rw    = rw;
    b0.addr  = a;
    b0.wdata = d;
    @(posedge clk);
    #1;
    b0.start = 1'b0;
    b0.rw    = ~rw;
    b0.addr  = ~a;
    b0.wdata = ~d;
  endtask

  // lat counts the accept edge as 1; busy_n counts busy samples taken after each edge.
  task automatic wait_done0(input int max_cyc, output int lat, output int busy_n);
    lat    = 1;
    busy_n = b0.busy ? 1 : 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (b0.done) break;
      if (b0.busy) busy_n++;
    end
    check("done_seen", b0.done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bn, gap, d0, w0;
    logic seen;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    b0.start = 1'b0; b0.rw = 1'b0; b0.addr = '0; b0.wdata = '0;
    b1.start = 1'b0; b1.rw = 1'b0; b1.addr = '0; b1.wdata = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) regs[k][i] = 8'(8'h11 * i);
      sh[k] = '0; last_frame[k] = '0; obuf[k] = '0; so[k] = 1'b0;
      sclk_p[k] = 1'b0; sv_p[k] = 1'b1; cnt[k] = 0; done_cnt[k] = 0; win_cnt[k] = 0;
    end
    regs[0][5] = 8'h3C;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", b0.busy, 1'b0);
    check("rst_done", b0.done, 1'b0);
    check("rst_rdata", b0.rdata, 8'h00);
    check("rst_sclk", b0.SCLK, 1'b0);
    check("rst_mosi", b0.MOSI, 1'b0);
    check("rst_svn", b0.SV_n, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write reg03 = 0xA5
    issue0(1'b0, 7'h03, 8'hA5);
    check("wr_accept_svn", b0.SV_n, 1'b0);
    wait_done0(400, lat, bn);
    check("wr_latency", lat, 153);
    check("wr_busy_cycles", bn, 152);
    check("wr_done_sclk", b0.SCLK, 1'b0);
    check("wr_done_svn", b0.SV_n, 1'b1);
    check("wr_rdata_hold", b0.rdata, 8'h00);
    @(posedge clk);
    #1;
    check("done_one_cycle", b0.done, 1'b0);
    check("wr_frame", last_frame[0], 16'h03A5);
    check("wr_commit", regs[0][3], 8'hA5);

    // Read reg05 (preloaded 0x3C)
    issue0(1'b1, 7'h05, 8'hFF);
    wait_done0(400, lat, bn);
    check("rd_latency", lat, 153);
    check("rd_rdata", b0.rdata, 8'h3C);
    check("rd_frame", last_frame[0], 16'h8500);

    // Write reg02 = 0x5B, rdata must hold
    issue0(1'b0, 7'h02, 8'h5B);
    wait_done0(400, lat, bn);
    check("wr2_rdata_hold", b0.rdata, 8'h3C);
    check("wr2_frame", last_frame[0], 16'h025B);
    check("wr2_commit", regs[0][2], 8'h5B);

    // start pulsed during SHIFT is ignored
    @(negedge clk);
    #1;
    d0 = done_cnt[0];
    w0 = win_cnt[0];
    issue0(1'b0, 7'h01, 8'h22);
    repeat (60) @(posedge clk);
    @(negedge clk);
    b0.start = 1'b1; b0.rw = 1'b0; b0.addr = 7'h04; b0.wdata = 8'h99;
    @(negedge clk);
    b0.start = 1'b0;
    wait_done0(400, lat, bn);
    @(negedge clk);
    #1;
    check("pulse_done_cnt", done_cnt[0] - d0, 1);
    check("pulse_windows", win_cnt[0] - w0, 1);
    repeat (200) @(posedge clk);
    #1;
    check("pulse_no_queue", done_cnt[0] - d0, 1);
    check("pulse_idle", b0.busy, 1'b0);
    check("pulse_commit", regs[0][1], 8'h22);
    check("pulse_reg4_kept", regs[0][4], 8'h44);

    // start held high through DONE: back-to-back frames
    @(negedge clk);
    b0.start = 1'b1; b0.rw = 1'b0; b0.addr = 7'h00; b0.wdata = 8'h5A;
    @(posedge clk);
    #1;
    gap  = 0;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (b0.SV_n) gap++;
      else gap = 0;
      if (b0.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b_first_done", seen, 1'b1);
    check("b2b_gap", gap, 17);
    @(posedge clk);
    #1;
    check("b2b_busy", b0.busy, 1'b1);
    check("b2b_svn", b0.SV_n, 1'b0);
    b0.start = 1'b0;
    wait_done0(400, lat, bn);
    check("b2b_latency", lat, 153);
    check("b2b_busy_cycles", bn, 152);
    check("b2b_commit", regs[0][0], 8'h5A);

    // Reset asserted at bit 10 aborts the frame
    @(negedge clk);
    #1;
    d0 = done_cnt[0];
    issue0(1'b0, 7'h06, 8'hEE);
    repeat (86) @(posedge clk);
    #1;
    check("abort_sclk_hi", b0.SCLK, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", b0.busy, 1'b0);
    check("abort_sclk", b0.SCLK, 1'b0);
    check("abort_mosi", b0.MOSI, 1'b0);
    check("abort_svn", b0.SV_n, 1'b1);
    check("abort_done", b0.done, 1'b0);
    check("abort_rdata", b0.rdata, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (250) @(posedge clk);
    @(negedge clk);
    #1;
    check("abort_no_done", done_cnt[0] - d0, 0);
    check("abort_reg6_kept", regs[0][6], 8'h66);

    // CLK_DIV=1, TAIL_CLKS=1 instance: write reg07 = 0x7F
    @(negedge clk);
    b1.start = 1'b1; b1.rw = 1'b0; b1.addr = 7'h07; b1.wdata = 8'h7F;
    @(posedge clk);
    #1;
    b1.start = 1'b0; b1.addr = 7'h00; b1.wdata = 8'h00;
    lat  = 1;
    bn   = b1.busy ? 1 : 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (b1.done) begin
        seen = 1'b1;
        break;
      end
      if (b1.busy) bn++;
    end
    check("fast_done_seen", seen, 1'b1);
    check("fast_busy_cycles", bn, 36);
    check("fast_latency", lat, 37);
    @(negedge clk);
    #1;
    check("fast_frame", last_frame[1], 16'h077F);
    check("fast_commit", regs[1][7], 8'h7F);
    check("fast_done_cnt", done_cnt[1], 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
